stream_group_min: RTL and testbench

//   Streaming front end for the 4-way unsigned min circuit. Accepts unsigned samples
//   one per cycle over a valid/ready handshake and groups them into frames of GROUP.

---
 rtl/stream_group_min.sv | 89 ++++++++
 tb/tb_stream_group_min.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_group_min.sv
// stream_group_min: groups valid/ready samples into frames of up to GROUP and emits each frame's minimum.
// Define MIN_INDEX_EN to add out_idx, the first position of the minimum within the frame.
module stream_group_min #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4,
    localparam int CW = $clog2(GROUP + 1),
    localparam int IW = $clog2(GROUP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [CW-1:0]    out_count,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MIN_INDEX_EN
    ,
    output logic [IW-1:0]    out_idx
`endif
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] run_min_q, run_min_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             accept, close, adopt;
    logic [WIDTH-1:0] min_nxt;

    // cnt is zero in HOLD, so a sample taken there always starts a fresh frame
    always_comb begin
        in_ready    = (state_q == ACCUM) || out_ready;
        accept      = in_valid && in_ready;
        adopt       = (cnt_q == '0) || (in_data < run_min_q);
        min_nxt     = adopt ? in_data : run_min_q;
        close       = accept && (in_last || cnt_q == CW'(GROUP - 1));
        run_min_d   = accept ? min_nxt : run_min_q;
        cnt_d       = close ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        out_min_d   = close ? min_nxt : out_min_q;
        out_count_d = close ? cnt_q + 1'b1 : out_count_q;
        state_d     = close ? HOLD : (out_valid && out_ready) ? ACCUM : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            run_min_q   <= '0;
            out_min_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_min_q   <= run_min_d;
            out_min_q   <= out_min_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_min   = out_min_q;
    assign out_count = out_count_q;

`ifdef MIN_INDEX_EN
    logic [IW-1:0] idx_q, idx_d, out_idx_q, out_idx_d, idx_nxt;

    always_comb begin
        idx_nxt   = adopt ? cnt_q[IW-1:0] : idx_q;
        idx_d     = accept ? idx_nxt : idx_q;
        out_idx_d = close ? idx_nxt : out_idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            out_idx_q <= '0;
        end else begin
            idx_q     <= idx_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign out_idx = out_idx_q;
`endif
endmodule

// File: tb/tb_stream_group_min.sv
// tb_stream_group_min: vector table, hand sequences and a randomized frame-level reference model.
module tb_stream_group_min;
    localparam int WIDTH = 8;
    localparam int GROUP = 4;
    localparam int CW = $clog2(GROUP + 1);
    localparam int IW = $clog2(GROUP);

    logic             clk = 0;
    logic             reset, in_valid, in_last, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_min;
    logic [CW-1:0]    out_count;
`ifdef MIN_INDEX_EN
    logic [IW-1:0]    out_idx;
`endif

    stream_group_min #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_min(out_min), .out_count(out_count), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MIN_INDEX_EN
        , .out_idx(out_idx)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic v; logic [7:0] d; logic l; logic r;
        logic ev; logic er; logic [7:0] em; int ec; int ei; logic cd;
    } vec_t;
    typedef struct {logic [7:0] m; int c; int ix;} res_t;

    vec_t tbl[$];
    res_t exp_q[$];
    logic [7:0] frame[$];
    int ntaken = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                       input logic ev, input logic er, input logic [7:0] em, input int ec,
                       input int ei, input logic cd);
        vec_t t;
        t = '{v, d, l, r, ev, er, em, ec, ei, cd};
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        exp_q.delete();
        frame.delete();
    endtask

    task automatic chk_res(input string tag, input logic [7:0] m, input int c, input int ix);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_min"}, out_min, m);
        chk({tag, "_count"}, out_count, c);
`ifdef MIN_INDEX_EN
        chk({tag, "_idx"}, out_idx, ix);
`else
        if (ix < 0) $display("bad index %0d", ix);
`endif
    endtask

    // Frame-level model: collect accepted samples, derive min/first index when the frame closes
    task automatic rcycle(input logic v, input logic [7:0] d, input logic l, input logic r);
        res_t e;
        drive(v, d, l, r);
        chk("rnd_valid", out_valid, exp_q.size() != 0);
        chk("rnd_in_ready", in_ready, !out_valid || r);
        if (out_valid && exp_q.size() != 0) begin
            chk_res("rnd", exp_q[0].m, exp_q[0].c, exp_q[0].ix);
            if (r) begin
                void'(exp_q.pop_front());
                ntaken++;
            end
        end
        if (v && in_ready) begin
            frame.push_back(d);
            if (l || frame.size() == GROUP) begin
                e.m = frame[0]; e.ix = 0; e.c = frame.size();
                for (int k = 1; k < frame.size(); k++)
                    if (frame[k] < e.m) begin e.m = frame[k]; e.ix = k; end
                exp_q.push_back(e);
                frame.delete();
            end
        end
    endtask

    initial begin
        int base;
        // frame 9,3,7,5
        add(1, 9, 0, 1, 0, 1, 0, 0, 0, 1);
        add(1, 3, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 7, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 5, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 3, 4, 1, 1);
        // ties 4,2,2,8
        add(1, 4, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 255, 0, 1, 1, 1, 2, 4, 1, 1);
        add(1, 255, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 255, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 255, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 255, 4, 0, 1);
        // early close, then the next frame restarts at cnt=0
        add(1, 200, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 100, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 6, 0, 1, 1, 1, 100, 2, 1, 1);
        add(1, 7, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 9, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 6, 4, 0, 1);
        add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        // one-sample frames; the second is taken while the first is consumed
        add(1, 30, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 20, 1, 1, 1, 1, 30, 1, 0, 1);
        add(0, 0, 0, 1, 1, 1, 20, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        reset = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("row%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("row%0d_ready", i), in_ready, tbl[i].er);
            if (tbl[i].cd) begin
                chk($sformatf("row%0d_min", i), out_min, tbl[i].em);
                chk($sformatf("row%0d_count", i), out_count, tbl[i].ec);
`ifdef MIN_INDEX_EN
                chk($sformatf("row%0d_idx", i), out_idx, tbl[i].ei);
`endif
            end
        end

        // backpressure: result held for 5 cycles, waiting sample not taken
        drive(1, 9, 0, 0); drive(1, 3, 0, 0); drive(1, 7, 0, 0); drive(1, 5, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 50, 0, 0);
            chk_res("bp_hold", 3, 4, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        drive(1, 50, 0, 1);
        chk_res("bp_take", 3, 4, 1);
        chk("bp_take_ready", in_ready, 1);
        drive(1, 60, 0, 1); chk("bp_f2_valid", out_valid, 0);
        drive(1, 70, 0, 1);
        drive(1, 80, 0, 1);
        drive(0, 0, 0, 1);
        chk_res("bp_f2", 50, 4, 0);
        drive(0, 0, 0, 1);

        // reset discards the partial frame
        drive(1, 1, 0, 1); drive(1, 1, 0, 1);
        @(negedge clk); reset = 1; in_valid = 0;
        @(negedge clk); reset = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_min", out_min, 0);
        drive(1, 10, 0, 1); chk("rst_f_valid0", out_valid, 0);
        drive(1, 20, 0, 1); chk("rst_f_valid1", out_valid, 0);
        drive(1, 30, 0, 1); chk("rst_f_valid2", out_valid, 0);
        drive(1, 40, 0, 1); chk("rst_f_valid3", out_valid, 0);
        drive(0, 0, 0, 1);
        chk_res("rst_f", 10, 4, 0);
        drive(0, 0, 0, 1);

        // back-to-back frames through the model
        exp_q.delete(); frame.delete();
        base = ntaken;
        for (int i = 0; i < 3 * GROUP; i++) rcycle(1, 8'($urandom), 0, 1);
        rcycle(0, 0, 0, 1); rcycle(0, 0, 0, 1);
        chk("b2b_results", ntaken - base, 3);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            rcycle($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                   $urandom_range(0, 6) == 0, $urandom_range(0, 9) < 7);
        rcycle(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) rcycle(0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
